alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Driver side of the ALU command interface: decodes a 16-bit instruction plus register operands into a
//  registered ALU command (in_a, in_b, cin, oper, inv_a, inv_b, sign). Commands are buffered in a
//  2-entry queue and presented to the ALU stage over a valid/ready handshake. Sits between decode and execute.
// PARAMETERS
//  WIDTH   16  operand width
//  DEPTH   2   command queue entries (power of two, >=2)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  instr_valid  in   1      instruction + operands valid
//  instr_ready  out  1      queue can accept (= !full; no combinational path from alu_ready)
//  instr        in   16     instruction; opcode [15:11], funct [1:0]
//  rs_data      in   WIDTH  Rs value
//  rt_data      in   WIDTH  Rt value
//  alu_valid    out  1      head command valid
//  alu_ready    in   1      ALU stage consumes head
//  in_a, in_b   out  WIDTH  operands
//  oper         out  4      ALU operation select
//  cin, inv_a, inv_b, sign  out 1 each  ALU modifiers
//  illegal      out  1      one-cycle pulse: accepted opcode not in table
// BEHAVIOUR
//  Reset: queue empty; alu_valid=0, illegal=0, all command outputs 0; counters 0.
//  Push on instr_valid&instr_ready; pop on alu_valid&alu_ready; both allowed same cycle.
//  Latency: accepted at edge N -> alu_valid high after edge N when queue was empty. Outputs are the head entry, registered.
//  Full: instr_ready=0, even if alu_ready=1 in same cycle. Empty: alu_valid=0, outputs hold last popped value.
//  Pointers wrap mod DEPTH; count 0..DEPTH tracked separately from pointers.
//  Decode (a=rs_data unless noted; b=rt_data or imm; default cin/inv/sign=0):
//   11011 f00 ADD oper=0100 | f01 SUB (Rt-Rs) 0100 inv_a cin | f10 XOR 0111 | f11 ANDN 0101 inv_b
//   01000 ADDI b=sext(i5) 0100 | 01001 SUBI b=sext(i5) 0100 inv_a cin
//   01010 XORI b=zext(i5) 0111 | 01011 ANDNI b=zext(i5) 0101 inv_b
//   11010 funct 00/01/10/11 ROL/SLL/ROR/SRL oper=00ff; 101ff ROLI..SRLI b=zext(instr[3:0])
//   11100 SEQ 1100, 11101 SLT 1101, 11110 SLE 1110: all inv_b cin sign
//   11111 SCO 1111 (no mods); 11001 BTR 1000; 11000 LBI a=sext(instr[7:0]) b=0 oper=0110
//  Illegal opcode: handshake completes, nothing pushed, illegal=1 next cycle only.
//  Reset mid-operation: queue contents discarded asynchronously; alu_valid drops immediately.
// CONFIGURATION
//  ALU_ISSUE_CNT_EN defined: adds out port issue_cnt[15:0], +1 per pop, wraps 0xFFFF->0, reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  alu_pkg: opcode constants, funct codes, OPER_* encodings, decoded-command width.
//  Sub-module alu_cmd_fifo: generic DEPTH x cmd-width queue with push/pop/full/empty; decode is combinational in alu_issue.
// TESTING
//  Reset: rst_n low mid-stream with 2 entries -> alu_valid=0, instr_ready=1 same cycle.
//  ADD rs=0x0003 rt=0x0004, alu_ready=1 -> next cycle in_a=3 in_b=4 oper=0100 cin=0 inv_a=0 inv_b=0.
//  SUB rs=5 rt=9 -> oper=0100 inv_a=1 cin=1; SLT -> oper=1101 inv_b=1 cin=1 sign=1.
//  ADDI imm5=0x1F -> in_b=0xFFFF; XORI imm5=0x1F -> in_b=0x001F; LBI 0x80 -> in_a=0xFF80 in_b=0.
//  alu_ready=0, 3 back-to-back instrs -> 2 accepted, instr_ready=0; release -> pop in order, none lost.
//  Opcode 00000 -> illegal pulse 1 cycle, alu_valid unchanged; ISSUE_CNT_EN: 0x10000 pops -> issue_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU issue stage: opcodes, funct
//               codes, ALU operation encodings and command width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcodes, instr[15:11]
  localparam logic [4:0] c_OP_ALU_R   = 5'b11011;
  localparam logic [4:0] c_OP_ADDI    = 5'b01000;
  localparam logic [4:0] c_OP_SUBI    = 5'b01001;
  localparam logic [4:0] c_OP_XORI    = 5'b01010;
  localparam logic [4:0] c_OP_ANDNI   = 5'b01011;
  localparam logic [4:0] c_OP_SHIFT_R = 5'b11010;
  localparam logic [4:0] c_OP_ROLI    = 5'b10100;
  localparam logic [4:0] c_OP_SLLI    = 5'b10101;
  localparam logic [4:0] c_OP_RORI    = 5'b10110;
  localparam logic [4:0] c_OP_SRLI    = 5'b10111;
  localparam logic [4:0] c_OP_SEQ     = 5'b11100;
  localparam logic [4:0] c_OP_SLT     = 5'b11101;
  localparam logic [4:0] c_OP_SLE     = 5'b11110;
  localparam logic [4:0] c_OP_SCO     = 5'b11111;
  localparam logic [4:0] c_OP_BTR     = 5'b11001;
  localparam logic [4:0] c_OP_LBI     = 5'b11000;

  // Funct codes for the register ALU group, instr[1:0]
  localparam logic [1:0] c_FN_ADD  = 2'b00;
  localparam logic [1:0] c_FN_SUB  = 2'b01;
  localparam logic [1:0] c_FN_XOR  = 2'b10;
  localparam logic [1:0] c_FN_ANDN = 2'b11;

  // ALU operation encodings
  localparam logic [3:0] c_OPER_ROL  = 4'b0000;
  localparam logic [3:0] c_OPER_SLL  = 4'b0001;
  localparam logic [3:0] c_OPER_ROR  = 4'b0010;
  localparam logic [3:0] c_OPER_SRL  = 4'b0011;
  localparam logic [3:0] c_OPER_ADD  = 4'b0100;
  localparam logic [3:0] c_OPER_ANDN = 4'b0101;
  localparam logic [3:0] c_OPER_LBI  = 4'b0110;
  localparam logic [3:0] c_OPER_XOR  = 4'b0111;
  localparam logic [3:0] c_OPER_BTR  = 4'b1000;
  localparam logic [3:0] c_OPER_SEQ  = 4'b1100;
  localparam logic [3:0] c_OPER_SLT  = 4'b1101;
  localparam logic [3:0] c_OPER_SLE  = 4'b1110;
  localparam logic [3:0] c_OPER_SCO  = 4'b1111;

  // Command layout: {in_a, in_b, oper[3:0], cin, inv_a, inv_b, sign}
  localparam int c_CMD_OPER_W = 4;
  localparam int c_CMD_MOD_W  = 4;

  function automatic int cmd_width(input int width);
    return 2 * width + c_CMD_OPER_W + c_CMD_MOD_W;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Generic DEPTH x DATA_W command queue with push/pop and
//               full/empty flags. Head output comes straight from storage
//               flops; when empty it shows the most recently popped entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_AW-1:0]   w_head_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == c_CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Popping never erases a slot, and the slot behind the read pointer can
  // only be rewritten after DEPTH pushes (queue non-empty by then), so when
  // empty that slot still holds the last popped command.
  assign w_head_idx = empty ? (r_rd_ptr - c_AW'(1)) : r_rd_ptr;
  assign head_data  = r_mem[w_head_idx];

  // Storage write on accepted push; cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy kept apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Decodes a 16-bit instruction plus register operands into an
//               ALU command, queues it and presents it over valid/ready.
//               Optional macro ALU_ISSUE_CNT_EN adds the issue_cnt port
//               counting issued (popped) commands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [WIDTH-1:0] in_a,
  output logic [WIDTH-1:0] in_b,
  output logic [3:0]       oper,
  output logic             cin,
  output logic             inv_a,
  output logic             inv_b,
  output logic             sign,
`ifdef ALU_ISSUE_CNT_EN
  output logic [15:0]      issue_cnt,
`endif
  output logic             illegal
);

  localparam int c_CMD_W = cmd_width(WIDTH);

  logic [4:0]         w_opcode;
  logic [1:0]         w_funct;
  logic [WIDTH-1:0]   w_imm5_sext;
  logic [WIDTH-1:0]   w_imm5_zext;
  logic [WIDTH-1:0]   w_imm4_zext;
  logic [WIDTH-1:0]   w_imm8_sext;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [3:0]         w_oper;
  logic               w_cin;
  logic               w_inv_a;
  logic               w_inv_b;
  logic               w_sign;
  logic               w_legal;
  logic [c_CMD_W-1:0] w_cmd_in;
  logic [c_CMD_W-1:0] w_cmd_head;
  logic               w_full;
  logic               w_empty;
  logic               r_illegal;
  logic               w_unused_ok;

  assign w_opcode    = instr[15:11];
  assign w_funct     = instr[1:0];
  assign w_imm5_sext = {{(WIDTH-5){instr[4]}}, instr[4:0]};
  assign w_imm5_zext = {{(WIDTH-5){1'b0}}, instr[4:0]};
  assign w_imm4_zext = {{(WIDTH-4){1'b0}}, instr[3:0]};
  assign w_imm8_sext = {{(WIDTH-8){instr[7]}}, instr[7:0]};
  assign w_unused_ok = &{1'b0, instr[10:8]};

  // Instruction decode into operands, operation and modifiers
  always_comb begin
    w_a     = rs_data;
    w_b     = rt_data;
    w_oper  = c_OPER_ADD;
    w_cin   = 1'b0;
    w_inv_a = 1'b0;
    w_inv_b = 1'b0;
    w_sign  = 1'b0;
    w_legal = 1'b1;
    case (w_opcode)
      c_OP_ALU_R: begin
        case (w_funct)
          c_FN_ADD: w_oper = c_OPER_ADD;
          // Rt - Rs computed as ~Rs + Rt + 1
          c_FN_SUB: begin w_inv_a = 1'b1; w_cin = 1'b1; end
          c_FN_XOR: w_oper = c_OPER_XOR;
          default:  begin w_oper = c_OPER_ANDN; w_inv_b = 1'b1; end
        endcase
      end
      c_OP_ADDI:  w_b = w_imm5_sext;
      c_OP_SUBI:  begin w_b = w_imm5_sext; w_inv_a = 1'b1; w_cin = 1'b1; end
      c_OP_XORI:  begin w_b = w_imm5_zext; w_oper = c_OPER_XOR; end
      c_OP_ANDNI: begin w_b = w_imm5_zext; w_oper = c_OPER_ANDN; w_inv_b = 1'b1; end
      c_OP_SHIFT_R: w_oper = {2'b00, w_funct};
      c_OP_ROLI, c_OP_SLLI, c_OP_RORI, c_OP_SRLI: begin
        w_b    = w_imm4_zext;
        w_oper = {2'b00, w_opcode[1:0]};
      end
      // Compares subtract Rt from Rs as a signed quantity
      c_OP_SEQ: begin w_oper = c_OPER_SEQ; w_inv_b = 1'b1; w_cin = 1'b1; w_sign = 1'b1; end
      c_OP_SLT: begin w_oper = c_OPER_SLT; w_inv_b = 1'b1; w_cin = 1'b1; w_sign = 1'b1; end
      c_OP_SLE: begin w_oper = c_OPER_SLE; w_inv_b = 1'b1; w_cin = 1'b1; w_sign = 1'b1; end
      c_OP_SCO: w_oper = c_OPER_SCO;
      c_OP_BTR: w_oper = c_OPER_BTR;
      c_OP_LBI: begin w_a = w_imm8_sext; w_b = '0; w_oper = c_OPER_LBI; end
      default:  w_legal = 1'b0;
    endcase
  end

  assign w_cmd_in = {w_a, w_b, w_oper, w_cin, w_inv_a, w_inv_b, w_sign};

  // Illegal opcodes still complete the handshake but are never queued
  alu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (c_CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (instr_valid & w_legal),
    .push_data (w_cmd_in),
    .pop       (alu_ready),
    .full      (w_full),
    .empty     (w_empty),
    .head_data (w_cmd_head)
  );

  assign instr_ready = ~w_full;
  assign alu_valid   = ~w_empty;
  assign {in_a, in_b, oper, cin, inv_a, inv_b, sign} = w_cmd_head;
  assign illegal     = r_illegal;

  // One-cycle pulse after an accepted instruction with an unknown opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= instr_valid & ~w_full & ~w_legal;
  end

`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] r_issue_cnt;

  // Count commands consumed by the ALU stage, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_issue_cnt <= '0;
    else if (alu_valid && alu_ready) r_issue_cnt <= r_issue_cnt + 16'd1;
  end

  assign issue_cnt = r_issue_cnt;
`endif

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Scoreboard bench for alu_issue: directed instructions with
//               hand-computed commands, decoupled in-order output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  oper;
    logic        cin;
    logic        inv_a;
    logic        inv_b;
    logic        sign;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] rs_data = '0;
  logic [15:0] rt_data = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [15:0] in_a, in_b;
  logic [3:0]  oper;
  logic        cin, inv_a, inv_b, sign;
  logic        illegal;
`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] issue_cnt;
`endif

  alu_issue #(.WIDTH(16), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .oper        (oper),
    .cin         (cin),
    .inv_a       (inv_a),
    .inv_b       (inv_b),
    .sign        (sign),
`ifdef ALU_ISSUE_CNT_EN
    .issue_cnt   (issue_cnt),
`endif
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  cmd_t sb[$];
  cmd_t cur_exp;
  logic cur_legal = 1'b0;
  cmd_t last_pop = '0;
  cmd_t dut_cmd;

  assign dut_cmd = {in_a, in_b, oper, cin, inv_a, inv_b, sign};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                              input logic ci, input logic ia, input logic ib, input logic sg);
    cmd_t c;
    c = {a, b, op, ci, ia, ib, sg};
    return c;
  endfunction

  // Scoreboard push: a legal instruction is accepted at the coming edge
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && cur_legal) sb.push_back(cur_exp);
  end

  // Monitor: the head is consumed at the coming edge; compare it in order
  always @(negedge clk) begin
    if (rst_n && alu_valid && alu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected no command", dut_cmd);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        check("alu_cmd", 64'(dut_cmd), 64'(e));
        last_pop = e;
        pops++;
      end
    end
  end

  // Present an instruction and wait (bounded) until it will be accepted
  task automatic send(input logic [15:0] ins, input logic [15:0] rs, input logic [15:0] rt,
                      input logic legal, input cmd_t exp);
    int n;
    n = 0;
    @(posedge clk); #1;
    instr = ins; rs_data = rs; rt_data = rt;
    cur_exp = exp; cur_legal = legal; instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr_ready=%0b required 1", instr_ready);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    cur_legal   = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    alu_ready = r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    // Reset state
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_alu_valid",   64'(alu_valid),   64'd0);
    check("rst_instr_ready", 64'(instr_ready), 64'd1);
    check("rst_illegal",     64'(illegal),     64'd0);
    check("rst_cmd",         64'(dut_cmd),     64'd0);

    // Single ADD: visible right after the accepting edge
    set_ready(1'b1);
    send(16'hD800, 16'h0003, 16'h0004, 1'b1, mk(16'h0003, 16'h0004, 4'b0100, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("add_latency_valid", 64'(alu_valid), 64'd1);
    instr_valid = 1'b0; cur_legal = 1'b0;

    // Streamed decode vectors
    send(16'hD801, 16'h0005, 16'h0009, 1'b1, mk(16'h0005, 16'h0009, 4'b0100, 1, 1, 0, 0));
    send(16'hE800, 16'h1234, 16'h5678, 1'b1, mk(16'h1234, 16'h5678, 4'b1101, 1, 0, 1, 1));
    send(16'h401F, 16'h0010, 16'h0000, 1'b1, mk(16'h0010, 16'hFFFF, 4'b0100, 0, 0, 0, 0));
    send(16'h501F, 16'h00AA, 16'h0000, 1'b1, mk(16'h00AA, 16'h001F, 4'b0111, 0, 0, 0, 0));
    send(16'hC080, 16'h1111, 16'h2222, 1'b1, mk(16'hFF80, 16'h0000, 4'b0110, 0, 0, 0, 0));
    send(16'h4802, 16'h0007, 16'h0000, 1'b1, mk(16'h0007, 16'h0002, 4'b0100, 1, 1, 0, 0));
    send(16'h5810, 16'h00FF, 16'h0000, 1'b1, mk(16'h00FF, 16'h0010, 4'b0101, 0, 0, 1, 0));
    send(16'hD803, 16'hF0F0, 16'h0FF0, 1'b1, mk(16'hF0F0, 16'h0FF0, 4'b0101, 0, 0, 1, 0));
    send(16'hD002, 16'h8001, 16'h0004, 1'b1, mk(16'h8001, 16'h0004, 4'b0010, 0, 0, 0, 0));
    send(16'hB81F, 16'hABCD, 16'h0000, 1'b1, mk(16'hABCD, 16'h000F, 4'b0011, 0, 0, 0, 0));
    send(16'hA003, 16'h0101, 16'h0000, 1'b1, mk(16'h0101, 16'h0003, 4'b0000, 0, 0, 0, 0));
    send(16'hE000, 16'h0042, 16'h0042, 1'b1, mk(16'h0042, 16'h0042, 4'b1100, 1, 0, 1, 1));
    send(16'hF000, 16'h0001, 16'h0002, 1'b1, mk(16'h0001, 16'h0002, 4'b1110, 1, 0, 1, 1));
    send(16'hF800, 16'h0003, 16'h0009, 1'b1, mk(16'h0003, 16'h0009, 4'b1111, 0, 0, 0, 0));
    send(16'hC800, 16'h00C3, 16'h0000, 1'b1, mk(16'h00C3, 16'h0000, 4'b1000, 0, 0, 0, 0));
    idle();
    drain();
    check("empty_valid_low", 64'(alu_valid), 64'd0);
    check("empty_hold_last", 64'(dut_cmd),   64'(last_pop));

    // Illegal opcode: handshake completes, nothing queued, one-cycle pulse
    send(16'h0000, 16'h1234, 16'h4321, 1'b0, '0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("illegal_pulse",       64'(illegal),   64'd1);
    check("illegal_no_valid",    64'(alu_valid), 64'd0);
    @(posedge clk); #1;
    check("illegal_pulse_end",   64'(illegal),   64'd0);
    check("illegal_hold_last",   64'(dut_cmd),   64'(last_pop));

    // Backpressure: three back-to-back with the ALU stalled
    p0 = pops;
    set_ready(1'b0);
    send(16'hD800, 16'h0001, 16'h0002, 1'b1, mk(16'h0001, 16'h0002, 4'b0100, 0, 0, 0, 0));
    send(16'hD802, 16'h00F0, 16'h0FF0, 1'b1, mk(16'h00F0, 16'h0FF0, 4'b0111, 0, 0, 0, 0));
    @(posedge clk); #1;
    instr = 16'hE800; rs_data = 16'h7777; rt_data = 16'h8888;
    cur_exp = mk(16'h7777, 16'h8888, 4'b1101, 1, 0, 1, 1); cur_legal = 1'b1;
    @(negedge clk);
    check("full_ready_low", 64'(instr_ready), 64'd0);
    check("full_valid",     64'(alu_valid),   64'd1);
    @(posedge clk); #1;
    alu_ready = 1'b1;
    @(negedge clk);
    check("full_ready_low_with_alu_ready", 64'(instr_ready), 64'd0);
    begin
      int n;
      n = 0;
      while (!instr_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("third_accepted", 64'(instr_ready), 64'd1);
    end
    idle();
    drain();
    check("backpressure_pops", 64'(pops - p0), 64'd3);

    // Reset mid-stream with two entries queued
    set_ready(1'b0);
    send(16'hD800, 16'h0011, 16'h0022, 1'b1, mk(16'h0011, 16'h0022, 4'b0100, 0, 0, 0, 0));
    send(16'hD800, 16'h0033, 16'h0044, 1'b1, mk(16'h0033, 16'h0044, 4'b0100, 0, 0, 0, 0));
    idle();
    check("pre_reset_full", 64'(instr_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_valid", 64'(alu_valid),   64'd0);
    check("reset_async_ready", 64'(instr_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    check("reset_cmd_zero", 64'(dut_cmd), 64'd0);
`ifdef ALU_ISSUE_CNT_EN
    check("reset_issue_cnt", 64'(issue_cnt), 64'd0);
`endif
    #2 rst_n = 1'b1;

`ifdef ALU_ISSUE_CNT_EN
    // 0x10000 issued commands wrap the counter back to zero
    p0 = pops;
    set_ready(1'b1);
    for (int i = 0; i < 65536; i++) begin
      send(16'hD800, 16'(i), 16'h0001, 1'b1, mk(16'(i), 16'h0001, 4'b0100, 0, 0, 0, 0));
      if (i == 65534) begin
        @(posedge clk); #2;
      end
    end
    idle();
    drain();
    check("cnt_pops", 64'(pops - p0), 64'd65536);
    check("cnt_wrap", 64'(issue_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_issue
`default_nettype wire
